// File: rtl/axi_reg_slice_pkg.sv
// rtl/axi_reg_slice_pkg.sv - shared AXI channel structs and slice default constants
package axi_reg_slice_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_LEN_W  = 8;

  localparam int AXI_SLICE_DEPTH_DEF      = 2;
  localparam int AXI_SLICE_DATA_DEPTH_DEF = 2 * AXI_SLICE_DEPTH_DEF;
  localparam int AXI_SLICE_OUTS_DEF       = 8;

  // valid is the MSB of every channel struct; the rest is the beat payload
  typedef struct packed {
    logic                  valid;
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ax_chan_t;

  typedef struct packed {
    logic                    valid;
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
  } w_chan_t;

  typedef struct packed {
    logic                  valid;
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_chan_t;

  typedef struct packed {
    logic                valid;
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } b_chan_t;

  typedef struct packed {
    logic ready;
  } rdy_t;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/AxiIO.sv
// rtl/AxiIO.sv - AXI bundle; m* members are driven by the master, s* members by the slave
interface AxiIO;
  import axi_reg_slice_pkg::*;

  ax_chan_t mar;
  ax_chan_t maw;
  w_chan_t  mw;
  rdy_t     mr;
  rdy_t     mb;
  rdy_t     sar;
  rdy_t     saw;
  rdy_t     sw;
  r_chan_t  sr;
  b_chan_t  sb;

  modport master (
    output mar, maw, mw, mr, mb,
    input  sar, saw, sw, sr, sb
  );

  modport slave (
    input  mar, maw, mw, mr, mb,
    output sar, saw, sw, sr, sb
  );
endinterface

// File: rtl/axi_chan_fifo.sv
// rtl/axi_chan_fifo.sv - single-channel valid/ready FIFO, power-of-2 depth, wrap-bit pointers
module axi_chan_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             rdy_en_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Ready depends only on flops, so a full FIFO rejects a push even in a pop cycle
  assign in_ready  = rdy_en_q && !full;
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

endmodule

// File: rtl/axi_reg_slice.sv
// rtl/axi_reg_slice.sv - AXI register slice with per-channel FIFOs and outstanding-burst limits
// Optional stall counters (rd_stall_cnt/wr_stall_cnt) are built when AXI_SLICE_STAT_EN is defined.
module axi_reg_slice
  import axi_reg_slice_pkg::*;
#(
  parameter int AR_DEPTH           = AXI_SLICE_DEPTH_DEF,
  parameter int R_DEPTH            = AXI_SLICE_DATA_DEPTH_DEF,
  parameter int AW_DEPTH           = AXI_SLICE_DEPTH_DEF,
  parameter int W_DEPTH            = AXI_SLICE_DATA_DEPTH_DEF,
  parameter int B_DEPTH            = AXI_SLICE_DEPTH_DEF,
  parameter int MAX_RD_OUTSTANDING = AXI_SLICE_OUTS_DEF,
  parameter int MAX_WR_OUTSTANDING = AXI_SLICE_OUTS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  AxiIO.slave         s_axi,
  AxiIO.master        m_axi
`ifdef AXI_SLICE_STAT_EN
  ,
  output logic [31:0] rd_stall_cnt,
  output logic [31:0] wr_stall_cnt
`endif
);

  localparam int RCW = cnt_width(MAX_RD_OUTSTANDING);
  localparam int WCW = cnt_width(MAX_WR_OUTSTANDING);
  localparam logic [RCW-1:0] RD_MAX = RCW'(MAX_RD_OUTSTANDING);
  localparam logic [WCW-1:0] WR_MAX = WCW'(MAX_WR_OUTSTANDING);

  logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
  logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
  logic           rd_limit, wr_limit;
  logic           ar_in_ready, aw_in_ready, w_in_ready, r_in_ready, b_in_ready;
  logic           ar_up_ready, aw_up_ready;
  logic           ar_out_valid, aw_out_valid, w_out_valid, r_out_valid, b_out_valid;
  logic           ar_hs, aw_hs, r_last_hs, b_hs;
  ax_chan_t       ar_raw, ar_head, aw_raw, aw_head;
  w_chan_t        w_raw, w_head;
  r_chan_t        r_raw, r_head;
  b_chan_t        b_raw, b_head;

  assign rd_limit    = (rd_cnt_q == RD_MAX);
  assign wr_limit    = (wr_cnt_q == WR_MAX);
  assign ar_up_ready = ar_in_ready && !rd_limit;
  assign aw_up_ready = aw_in_ready && !wr_limit;

  axi_chan_fifo #(.DEPTH(AR_DEPTH), .WIDTH($bits(ax_chan_t))) u_ar_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_axi.mar.valid && !rd_limit),
    .in_ready (ar_in_ready),
    .in_data  (s_axi.mar),
    .out_valid(ar_out_valid),
    .out_ready(m_axi.sar.ready),
    .out_data (ar_raw)
  );

  axi_chan_fifo #(.DEPTH(AW_DEPTH), .WIDTH($bits(ax_chan_t))) u_aw_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_axi.maw.valid && !wr_limit),
    .in_ready (aw_in_ready),
    .in_data  (s_axi.maw),
    .out_valid(aw_out_valid),
    .out_ready(m_axi.saw.ready),
    .out_data (aw_raw)
  );

  // W is deliberately not gated by wr_cnt: data may run ahead of its address
  axi_chan_fifo #(.DEPTH(W_DEPTH), .WIDTH($bits(w_chan_t))) u_w_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_axi.mw.valid),
    .in_ready (w_in_ready),
    .in_data  (s_axi.mw),
    .out_valid(w_out_valid),
    .out_ready(m_axi.sw.ready),
    .out_data (w_raw)
  );

  axi_chan_fifo #(.DEPTH(R_DEPTH), .WIDTH($bits(r_chan_t))) u_r_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (m_axi.sr.valid),
    .in_ready (r_in_ready),
    .in_data  (m_axi.sr),
    .out_valid(r_out_valid),
    .out_ready(s_axi.mr.ready),
    .out_data (r_raw)
  );

  axi_chan_fifo #(.DEPTH(B_DEPTH), .WIDTH($bits(b_chan_t))) u_b_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (m_axi.sb.valid),
    .in_ready (b_in_ready),
    .in_data  (m_axi.sb),
    .out_valid(b_out_valid),
    .out_ready(s_axi.mb.ready),
    .out_data (b_raw)
  );

  // Stored valid bits are stale; each head's valid comes from FIFO occupancy
  always_comb begin
    ar_head       = ar_raw;
    ar_head.valid = ar_out_valid;
    aw_head       = aw_raw;
    aw_head.valid = aw_out_valid;
    w_head        = w_raw;
    w_head.valid  = w_out_valid;
    r_head        = r_raw;
    r_head.valid  = r_out_valid;
    b_head        = b_raw;
    b_head.valid  = b_out_valid;
  end

  assign m_axi.mar = ar_head;
  assign m_axi.maw = aw_head;
  assign m_axi.mw  = w_head;
  assign m_axi.mr  = '{ready: r_in_ready};
  assign m_axi.mb  = '{ready: b_in_ready};
  assign s_axi.sar = '{ready: ar_up_ready};
  assign s_axi.saw = '{ready: aw_up_ready};
  assign s_axi.sw  = '{ready: w_in_ready};
  assign s_axi.sr  = r_head;
  assign s_axi.sb  = b_head;

  assign ar_hs     = s_axi.mar.valid && ar_up_ready;
  assign aw_hs     = s_axi.maw.valid && aw_up_ready;
  assign r_last_hs = r_out_valid && s_axi.mr.ready && r_head.last;
  assign b_hs      = b_out_valid && s_axi.mb.ready;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (ar_hs && !r_last_hs) begin
      rd_cnt_d = rd_cnt_q + RCW'(1);
    end else if (!ar_hs && r_last_hs) begin
      rd_cnt_d = rd_cnt_q - RCW'(1);
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (aw_hs && !b_hs) begin
      wr_cnt_d = wr_cnt_q + WCW'(1);
    end else if (!aw_hs && b_hs) begin
      wr_cnt_d = wr_cnt_q - WCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

`ifdef AXI_SLICE_STAT_EN
  logic [31:0] rd_stall_q, rd_stall_d;
  logic [31:0] wr_stall_q, wr_stall_d;

  always_comb begin
    rd_stall_d = rd_stall_q;
    wr_stall_d = wr_stall_q;
    if (s_axi.mar.valid && !ar_up_ready && (rd_stall_q != 32'hFFFF_FFFF)) begin
      rd_stall_d = rd_stall_q + 32'd1;
    end
    if (s_axi.maw.valid && !aw_up_ready && (wr_stall_q != 32'hFFFF_FFFF)) begin
      wr_stall_d = wr_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_stall_q <= '0;
      wr_stall_q <= '0;
    end else begin
      rd_stall_q <= rd_stall_d;
      wr_stall_q <= wr_stall_d;
    end
  end

  assign rd_stall_cnt = rd_stall_q;
  assign wr_stall_cnt = wr_stall_q;
`endif

`ifndef SYNTHESIS
  // The ready gating makes overflow impossible; underflow means a protocol-violating slave
  always @(posedge clk) begin
    if (rst) begin
      assert (!(rd_limit && ar_hs && !r_last_hs));
      assert (!((rd_cnt_q == '0) && r_last_hs && !ar_hs));
      assert (!(wr_limit && aw_hs && !b_hs));
      assert (!((wr_cnt_q == '0) && b_hs && !aw_hs));
    end
  end
`endif

endmodule

// File: tb/tb_axi_reg_slice.sv
// tb/tb_axi_reg_slice.sv - directed self-checking bench for axi_reg_slice
module tb_axi_reg_slice;
  import axi_reg_slice_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  AxiIO s_if ();
  AxiIO m_if ();

`ifdef AXI_SLICE_STAT_EN
  logic [31:0] rd_stall;
  logic [31:0] wr_stall;
`endif

  axi_reg_slice #(.MAX_RD_OUTSTANDING(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_axi(s_if),
    .m_axi(m_if)
`ifdef AXI_SLICE_STAT_EN
    ,
    .rd_stall_cnt(rd_stall),
    .wr_stall_cnt(wr_stall)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_if.mar = '0;
    s_if.maw = '0;
    s_if.mw  = '0;
    s_if.mr  = '0;
    s_if.mb  = '0;
    m_if.sar = '0;
    m_if.saw = '0;
    m_if.sw  = '0;
    m_if.sr  = '0;
    m_if.sb  = '0;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    s_if.mar.valid = 1'b1;
    m_if.sr.valid  = 1'b1;
    tick();
    tick();
    checks++; if (s_if.sar.ready !== 1'b0) begin errors++; $display("FAIL rst_sar_ready: got %b exp 0", s_if.sar.ready); end
    checks++; if (s_if.sw.ready !== 1'b0) begin errors++; $display("FAIL rst_sw_ready: got %b exp 0", s_if.sw.ready); end
    checks++; if (m_if.mr.ready !== 1'b0) begin errors++; $display("FAIL rst_mr_ready: got %b exp 0", m_if.mr.ready); end
    checks++; if (m_if.mar.valid !== 1'b0) begin errors++; $display("FAIL rst_mar_valid: got %b exp 0", m_if.mar.valid); end
    checks++; if (s_if.sr.valid !== 1'b0) begin errors++; $display("FAIL rst_sr_valid: got %b exp 0", s_if.sr.valid); end
    idle();
    rst = 1'b1;
    #1;
    checks++; if (s_if.sar.ready !== 1'b0) begin errors++; $display("FAIL rel_before_edge_sar_ready: got %b exp 0", s_if.sar.ready); end
    tick();
    checks++; if (s_if.sar.ready !== 1'b1) begin errors++; $display("FAIL rel_sar_ready: got %b exp 1", s_if.sar.ready); end
    checks++; if (s_if.saw.ready !== 1'b1) begin errors++; $display("FAIL rel_saw_ready: got %b exp 1", s_if.saw.ready); end
    checks++; if (s_if.sw.ready !== 1'b1) begin errors++; $display("FAIL rel_sw_ready: got %b exp 1", s_if.sw.ready); end
    checks++; if (m_if.mr.ready !== 1'b1) begin errors++; $display("FAIL rel_mr_ready: got %b exp 1", m_if.mr.ready); end
    checks++; if (m_if.mb.ready !== 1'b1) begin errors++; $display("FAIL rel_mb_ready: got %b exp 1", m_if.mb.ready); end
  endtask

  task automatic test_ar_latency();
    apply_reset();
    m_if.sar.ready = 1'b1;
    s_if.mar = '{valid: 1'b1, id: 4'h5, addr: 32'h1000_0040, len: 8'd3, size: 3'd2, burst: 2'b01};
    checks++; if (m_if.mar.valid !== 1'b0) begin errors++; $display("FAIL ar_cycle0_valid: got %b exp 0", m_if.mar.valid); end
    tick();
    s_if.mar = '0;
    checks++; if (m_if.mar.valid !== 1'b1) begin errors++; $display("FAIL ar_cycle1_valid: got %b exp 1", m_if.mar.valid); end
    checks++; if (m_if.mar.id !== 4'h5) begin errors++; $display("FAIL ar_id: got %h exp 5", m_if.mar.id); end
    checks++; if (m_if.mar.addr !== 32'h1000_0040) begin errors++; $display("FAIL ar_addr: got %h exp 10000040", m_if.mar.addr); end
    checks++; if (m_if.mar.len !== 8'd3) begin errors++; $display("FAIL ar_len: got %0d exp 3", m_if.mar.len); end
    tick();
    checks++; if (m_if.mar.valid !== 1'b0) begin errors++; $display("FAIL ar_drained_valid: got %b exp 0", m_if.mar.valid); end
  endtask

  task automatic test_w_backpressure();
    apply_reset();
    m_if.sw.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_if.mw = '{valid: 1'b1, data: 32'hA0 + 32'(i), strb: 4'hF, last: 1'b0};
      checks++; if (s_if.sw.ready !== 1'b1) begin errors++; $display("FAIL w_fill_ready beat %0d: got %b exp 1", i, s_if.sw.ready); end
      tick();
    end
    s_if.mw = '{valid: 1'b1, data: 32'hA4, strb: 4'hF, last: 1'b1};
    checks++; if (s_if.sw.ready !== 1'b0) begin errors++; $display("FAIL w_full_ready: got %b exp 0", s_if.sw.ready); end
    tick();
    checks++; if (s_if.sw.ready !== 1'b0) begin errors++; $display("FAIL w_full_hold_ready: got %b exp 0", s_if.sw.ready); end
    checks++; if (m_if.mw.data !== 32'hA0) begin errors++; $display("FAIL w_head_data: got %h exp a0", m_if.mw.data); end
    m_if.sw.ready = 1'b1;
    checks++; if (s_if.sw.ready !== 1'b0) begin errors++; $display("FAIL w_no_comb_path: got %b exp 0", s_if.sw.ready); end
    tick();
    checks++; if (s_if.sw.ready !== 1'b1) begin errors++; $display("FAIL w_after_pop_ready: got %b exp 1", s_if.sw.ready); end
    tick();
    s_if.mw = '0;
    for (int j = 2; j < 5; j++) begin
      checks++; if (m_if.mw.valid !== 1'b1 || m_if.mw.data !== 32'hA0 + 32'(j)) begin errors++; $display("FAIL w_order beat %0d: got v=%b d=%h exp v=1 d=%h", j, m_if.mw.valid, m_if.mw.data, 32'hA0 + 32'(j)); end
      if (j == 4) begin
        checks++; if (m_if.mw.last !== 1'b1) begin errors++; $display("FAIL w_last: got %b exp 1", m_if.mw.last); end
      end
      tick();
    end
    checks++; if (m_if.mw.valid !== 1'b0) begin errors++; $display("FAIL w_empty_valid: got %b exp 0", m_if.mw.valid); end
  endtask

  task automatic test_rd_outstanding();
    apply_reset();
    m_if.sar.ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      s_if.mar = '{valid: 1'b1, id: 4'(i), addr: 32'h2000 + 32'(i * 16), len: 8'd0, size: 3'd2, burst: 2'b01};
      checks++; if (s_if.sar.ready !== 1'b1) begin errors++; $display("FAIL rd_out_accept ar %0d: got %b exp 1", i, s_if.sar.ready); end
      tick();
    end
    s_if.mar = '{valid: 1'b1, id: 4'h3, addr: 32'h2030, len: 8'd0, size: 3'd2, burst: 2'b01};
    checks++; if (s_if.sar.ready !== 1'b0) begin errors++; $display("FAIL rd_out_stall: got %b exp 0", s_if.sar.ready); end
    tick();
    checks++; if (s_if.sar.ready !== 1'b0) begin errors++; $display("FAIL rd_out_stall_hold: got %b exp 0", s_if.sar.ready); end
    checks++; if (dut.rd_cnt_q !== 2'd2) begin errors++; $display("FAIL rd_out_cnt_max: got %0d exp 2", dut.rd_cnt_q); end
    m_if.sr = '{valid: 1'b1, id: 4'h1, data: 32'hD00D_0001, resp: 2'b00, last: 1'b1};
    s_if.mr.ready = 1'b1;
    tick();
    m_if.sr = '0;
    checks++; if (s_if.sr.valid !== 1'b1 || s_if.sr.data !== 32'hD00D_0001) begin errors++; $display("FAIL rd_out_r_fwd: got v=%b d=%h exp v=1 d=d00d0001", s_if.sr.valid, s_if.sr.data); end
    checks++; if (s_if.sar.ready !== 1'b0) begin errors++; $display("FAIL rd_out_before_rlast: got %b exp 0", s_if.sar.ready); end
    tick();
    checks++; if (s_if.sar.ready !== 1'b1) begin errors++; $display("FAIL rd_out_after_rlast: got %b exp 1", s_if.sar.ready); end
    tick();
    s_if.mar = '0;
    checks++; if (dut.rd_cnt_q !== 2'd2) begin errors++; $display("FAIL rd_out_cnt_third: got %0d exp 2", dut.rd_cnt_q); end
    checks++; if (m_if.mar.valid !== 1'b1 || m_if.mar.id !== 4'h3) begin errors++; $display("FAIL rd_out_third_fwd: got v=%b id=%h exp v=1 id=3", m_if.mar.valid, m_if.mar.id); end
  endtask

  task automatic test_rd_same_cycle();
    apply_reset();
    m_if.sar.ready = 1'b1;
    s_if.mar = '{valid: 1'b1, id: 4'h4, addr: 32'h3000, len: 8'd0, size: 3'd2, burst: 2'b01};
    tick();
    s_if.mar = '0;
    m_if.sr = '{valid: 1'b1, id: 4'h4, data: 32'h1234_5678, resp: 2'b00, last: 1'b1};
    tick();
    m_if.sr = '0;
    s_if.mr.ready = 1'b1;
    s_if.mar = '{valid: 1'b1, id: 4'h5, addr: 32'h3010, len: 8'd0, size: 3'd2, burst: 2'b01};
    checks++; if (s_if.sar.ready !== 1'b1 || s_if.sr.valid !== 1'b1) begin errors++; $display("FAIL same_cycle_setup: got rdy=%b rv=%b exp 1 1", s_if.sar.ready, s_if.sr.valid); end
    checks++; if (dut.rd_cnt_q !== 2'd1) begin errors++; $display("FAIL same_cycle_cnt_before: got %0d exp 1", dut.rd_cnt_q); end
    tick();
    s_if.mar = '0;
    checks++; if (dut.rd_cnt_q !== 2'd1) begin errors++; $display("FAIL same_cycle_cnt_after: got %0d exp 1", dut.rd_cnt_q); end
    checks++; if (s_if.sr.valid !== 1'b0) begin errors++; $display("FAIL same_cycle_r_drained: got %b exp 0", s_if.sr.valid); end
  endtask

  task automatic test_write_resp();
    apply_reset();
    m_if.saw.ready = 1'b1;
    s_if.maw = '{valid: 1'b1, id: 4'h7, addr: 32'h4000, len: 8'd0, size: 3'd2, burst: 2'b01};
    tick();
    s_if.maw = '0;
    checks++; if (m_if.maw.valid !== 1'b1 || m_if.maw.id !== 4'h7) begin errors++; $display("FAIL aw_fwd: got v=%b id=%h exp v=1 id=7", m_if.maw.valid, m_if.maw.id); end
    checks++; if (dut.wr_cnt_q !== 4'd1) begin errors++; $display("FAIL wr_cnt_inc: got %0d exp 1", dut.wr_cnt_q); end
    m_if.sb = '{valid: 1'b1, id: 4'h7, resp: 2'b10};
    s_if.mb.ready = 1'b1;
    tick();
    m_if.sb = '0;
    checks++; if (s_if.sb.valid !== 1'b1 || s_if.sb.id !== 4'h7 || s_if.sb.resp !== 2'b10) begin errors++; $display("FAIL b_fwd: got v=%b id=%h r=%b exp v=1 id=7 r=10", s_if.sb.valid, s_if.sb.id, s_if.sb.resp); end
    tick();
    checks++; if (s_if.sb.valid !== 1'b0) begin errors++; $display("FAIL b_drained: got %b exp 0", s_if.sb.valid); end
    checks++; if (dut.wr_cnt_q !== 4'd0) begin errors++; $display("FAIL wr_cnt_dec: got %0d exp 0", dut.wr_cnt_q); end
  endtask

  task automatic test_reset_midburst();
    apply_reset();
    s_if.mr.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_if.sr = '{valid: 1'b1, id: 4'h2, data: 32'hB000 + 32'(i), resp: 2'b00, last: 1'b0};
      tick();
    end
    m_if.sr = '0;
    checks++; if (s_if.sr.valid !== 1'b1 || s_if.sr.data !== 32'hB000) begin errors++; $display("FAIL midrst_buffered: got v=%b d=%h exp v=1 d=b000", s_if.sr.valid, s_if.sr.data); end
    rst = 1'b0;
    #1;
    checks++; if (s_if.sr.valid !== 1'b0) begin errors++; $display("FAIL midrst_async_valid: got %b exp 0", s_if.sr.valid); end
    checks++; if (m_if.mr.ready !== 1'b0) begin errors++; $display("FAIL midrst_async_ready: got %b exp 0", m_if.mr.ready); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (s_if.sr.valid !== 1'b0) begin errors++; $display("FAIL midrst_empty_after: got %b exp 0", s_if.sr.valid); end
    m_if.sr = '{valid: 1'b1, id: 4'h9, data: 32'hC0FF_EE00, resp: 2'b00, last: 1'b0};
    tick();
    m_if.sr = '0;
    s_if.mr.ready = 1'b1;
    checks++; if (s_if.sr.valid !== 1'b1 || s_if.sr.data !== 32'hC0FF_EE00) begin errors++; $display("FAIL midrst_new_beat: got v=%b d=%h exp v=1 d=c0ffee00", s_if.sr.valid, s_if.sr.data); end
    tick();
    checks++; if (s_if.sr.valid !== 1'b0) begin errors++; $display("FAIL midrst_single_entry: got %b exp 0", s_if.sr.valid); end
  endtask

`ifdef AXI_SLICE_STAT_EN
  task automatic test_stall_stats();
    apply_reset();
    checks++; if (rd_stall !== 32'd0) begin errors++; $display("FAIL stat_reset: got %0d exp 0", rd_stall); end
    m_if.sar.ready = 1'b1;
    s_if.mar = '{valid: 1'b1, id: 4'h1, addr: 32'h5000, len: 8'd0, size: 3'd2, burst: 2'b01};
    repeat (12) tick();
    s_if.mar = '0;
    checks++; if (rd_stall !== 32'd10) begin errors++; $display("FAIL stat_rd_10: got %0d exp 10", rd_stall); end
    checks++; if (wr_stall !== 32'd0) begin errors++; $display("FAIL stat_wr_zero: got %0d exp 0", wr_stall); end
    dut.rd_stall_q = 32'hFFFF_FFFE;
    s_if.mar = '{valid: 1'b1, id: 4'h1, addr: 32'h5000, len: 8'd0, size: 3'd2, burst: 2'b01};
    repeat (3) tick();
    s_if.mar = '0;
    checks++; if (rd_stall !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stat_saturate: got %h exp ffffffff", rd_stall); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ar_latency();
    test_w_backpressure();
    test_rd_outstanding();
    test_rd_same_cycle();
    test_write_resp();
    test_reset_midburst();
`ifdef AXI_SLICE_STAT_EN
    test_stall_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_reg_slice.md
AXI_REG_SLICE -- requirements
Module: axi_reg_slice

Interface
REQ-001 SHALL have parameter AR_DEPTH, default 2, meaning the AR channel buffer entries (power of 2, ≥2).
REQ-002 SHALL have parameter R_DEPTH, default 4, meaning the R channel buffer entries (power of 2, ≥2).
REQ-003 SHALL have parameter AW_DEPTH, default 2, meaning the AW channel buffer entries (power of 2, ≥2).
REQ-004 SHALL have parameter W_DEPTH, default 4, meaning the W channel buffer entries (power of 2, ≥2).
REQ-005 SHALL have parameter B_DEPTH, default 2, meaning the B channel buffer entries (power of 2, ≥2).
REQ-006 SHALL have parameter MAX_RD_OUTSTANDING, default 8, meaning the read bursts in flight limit (≥1).
REQ-007 SHALL have parameter MAX_WR_OUTSTANDING, default 8, meaning the write bursts in flight limit (≥1).
REQ-008 SHALL have ports: clk  input  1  single clock; all state on rising edge.
REQ-009 SHALL have ports: rst  input  1  asynchronous, active-low reset.
REQ-010 SHALL have ports: s_axi  AxiIO.slave  -  upstream side; the master connects here.
REQ-011 SHALL have ports: m_axi  AxiIO.master  -  downstream side; goes to the slave.
REQ-012 SHALL, with AXI_SLICE_STAT_EN, have ports: rd_stall_cnt  output  32  and wr_stall_cnt  output  32.

Function
REQ-013 SHALL carry each of the five channels through an independent FIFO: AR/AW/W run s->m, R/B run m->s.
REQ-014 SHALL forward whole structs unmodified, with valid regenerated from the FIFO state.
REQ-015 SHALL drive FIFO input ready = !full from a register only, with no combinational path from output ready to input ready.
REQ-016 SHALL drive FIFO output valid = !empty and output payload from the head entry.
REQ-017 SHALL give one cycle minimum latency: an entry accepted at edge N is visible downstream from cycle N+1.
REQ-018 SHALL reject a push while full even if a pop occurs the same cycle.
REQ-019 SHALL perform push and pop together when not full and not empty; count unchanged.
REQ-020 SHALL ignore a pop while empty.
REQ-021 SHALL wrap pointers modulo depth, using an extra wrap bit to distinguish full from empty.
REQ-022 SHALL use rd_cnt, width clog2(MAX_RD_OUTSTANDING+1): +1 on s_axi AR handshake, −1 on s_axi R handshake with last=1, unchanged when both occur.
REQ-023 SHALL use wr_cnt the same way: +1 on s_axi AW handshake, −1 on s_axi B handshake.
REQ-024 SHALL force s_axi.sar.ready = 0 when rd_cnt == MAX_RD_OUTSTANDING.
REQ-025 SHALL force s_axi.saw.ready = 0 when wr_cnt == MAX_WR_OUTSTANDING.
REQ-026 SHALL NOT gate W by wr_cnt; W data may lead AW, limited only by W_DEPTH.
REQ-027 SHALL NOT reorder: per-channel FIFO order is preserved; ID-based reordering is outside scope.
REQ-028 SHALL leave counter overflow/underflow unreachable by protocol; an assertion checks it in simulation only.

Reset
REQ-029 SHALL, on rst=0 asynchronously, clear all FIFO pointers, rd_cnt, wr_cnt and stat counters.
REQ-030 SHALL hold all output valids at 0 and all upstream readies at 0 while rst=0.
REQ-031 SHALL assert upstream readies from the first edge after rst deasserts.
REQ-032 SHALL, on reset mid-burst, discard buffered beats; there is no recovery.
REQ-033 SHALL NOT reset FIFO payload storage.

Configuration
REQ-034 SHALL control statistics with macro AXI_SLICE_STAT_EN.
REQ-035 SHALL, when AXI_SLICE_STAT_EN is defined, increment rd_stall_cnt each cycle s_axi.mar.valid=1 and sar.ready=0, and wr_stall_cnt likewise for AW; both saturate at 32'hFFFF_FFFF.
REQ-036 SHALL, when AXI_SLICE_STAT_EN is undefined, omit the counters and their ports; datapath behaviour is identical.

Structure
REQ-037 SHALL place default depth/outstanding constants (AXI_SLICE_DEPTH_DEF, AXI_SLICE_OUTS_DEF) in the shared AXI defines header, alongside the channel structs.
REQ-038 SHALL implement one sub-module, axi_chan_fifo, parametrised by DEPTH and payload type/width with valid/ready on both sides, and instantiate it five times.
REQ-039 SHALL keep outstanding counters and stat logic in the top level.

Verification
REQ-040 SHALL cover: AR at cycle 0, m ar ready=1 -> m_axi.mar.valid=1 at cycle 1 with identical id/addr/len.
REQ-041 SHALL cover: m_axi.sw.ready held 0, 5 W beats offered, W_DEPTH=4 -> 4 accepted, s_axi.sw.ready=0 after the 4th, 5th accepted one cycle after the first downstream pop.
REQ-042 SHALL cover: MAX_RD_OUTSTANDING=2, 3 ARs with no R returned -> third AR stalls; R last delivered -> third accepted the following cycle.
REQ-043 SHALL cover: AR handshake and R last handshake in the same cycle at rd_cnt=1 -> rd_cnt stays 1.
REQ-044 SHALL cover: rst pulsed low with 3 R beats buffered -> s_axi.sr.valid=0 immediately, FIFO empty after release.
REQ-045 SHALL cover, with AXI_SLICE_STAT_EN: AR valid stalled 10 cycles -> rd_stall_cnt=10; preload 32'hFFFF_FFFE and stall 3 cycles -> holds 32'hFFFF_FFFF.
